// File: rtl/fft_stream_ctrl.sv
// fft_stream_ctrl: frame-at-a-time loader/unloader around a combinational N-point fft.
module fft #(
    parameter int N     = 4,
    parameter int WIDTH = 12
) (
    input  logic signed [WIDTH-1:0] x [N][2],
    output logic signed [WIDTH-1:0] y [N][2]
);
    localparam int  F   = WIDTH - 1;
    localparam int  ACC = 2 * WIDTH + $clog2(N) + 3;
    localparam real SC  = 2.0 ** F;
    for (genvar k = 0; k < N; k++) begin : g_bin
        logic signed [ACC-1:0] tr [N];
        logic signed [ACC-1:0] ti [N];
        logic signed [ACC-1:0] sr, si;
        for (genvar n = 0; n < N; n++) begin : g_tap
            // twiddle W^(nk) = C - jS, scaled by 2^F so quarter-turn twiddles are exact
            localparam real A = 6.283185307179586 * ((n * k) % N) / N;
            localparam logic signed [ACC-1:0] C = ACC'($rtoi($floor($cos(A) * SC + 0.5)));
            localparam logic signed [ACC-1:0] S = ACC'($rtoi($floor($sin(A) * SC + 0.5)));
            logic signed [ACC-1:0] xr, xi;
            assign xr    = ACC'(x[n][0]);
            assign xi    = ACC'(x[n][1]);
            assign tr[n] = xr * C + xi * S;
            assign ti[n] = xi * C - xr * S;
        end
        always_comb begin
            sr = '0;
            si = '0;
            for (int i = 0; i < N; i++) begin
                sr = sr + tr[i];
                si = si + ti[i];
            end
        end
        assign y[k][0] = WIDTH'(sr >>> F);
        assign y[k][1] = WIDTH'(si >>> F);
    end
endmodule

module fft_stream_ctrl #(
    parameter int N     = 4,
    parameter int WIDTH = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic signed [WIDTH-1:0]  in_re,
    input  logic signed [WIDTH-1:0]  in_im,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [WIDTH-1:0]  out_re,
    output logic signed [WIDTH-1:0]  out_im,
    output logic [$clog2(N)-1:0]     out_idx,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     busy,
    output logic [15:0]              frame_cnt
);
    localparam int IW = $clog2(N);
    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;
    state_t state, state_nx;
    logic [IW-1:0] cnt, cnt_nx;
    logic run, in_xfer, out_xfer, at_end;
    logic signed [WIDTH-1:0] ibuf [N][2];
    logic signed [WIDTH-1:0] obuf [N][2];
    logic signed [WIDTH-1:0] fo   [N][2];

    fft #(.N(N), .WIDTH(WIDTH)) u_fft (.x(ibuf), .y(fo));

    // run keeps in_ready low until the first edge after reset release
    assign in_ready  = run && state == LOAD;
    assign out_valid = state == UNLOAD;
    assign busy      = state != LOAD;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign at_end    = cnt == IW'(N - 1);
    assign out_re    = obuf[cnt][0];
    assign out_im    = obuf[cnt][1];
    assign out_idx   = cnt;
    assign out_last  = out_valid && at_end;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            LOAD: begin
                cnt_nx   = in_xfer ? cnt + IW'(1) : cnt;
                state_nx = in_xfer && at_end ? COMPUTE : LOAD;
            end
            COMPUTE: state_nx = UNLOAD;
            UNLOAD: begin
                cnt_nx   = out_xfer ? cnt + IW'(1) : cnt;
                state_nx = out_xfer && at_end ? LOAD : UNLOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            cnt       <= '0;
            run       <= 1'b0;
            frame_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                ibuf[i][0] <= '0;
                ibuf[i][1] <= '0;
                obuf[i][0] <= '0;
                obuf[i][1] <= '0;
            end
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            run   <= 1'b1;
            if (in_xfer) begin
                ibuf[cnt][0] <= in_re;
                ibuf[cnt][1] <= in_im;
            end
            if (state == COMPUTE) obuf <= fo;
            if (out_xfer && at_end) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fft_stream_ctrl.sv
// tb_fft_stream_ctrl: directed and random frames checked against a 4-point DFT model.
module tb_fft_stream_ctrl;
    localparam int N = 4;
    localparam int W = 12;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] in_re = '0, in_im = '0;
    logic in_ready, out_valid, out_last, busy;
    logic [W-1:0] out_re, out_im;
    logic [1:0] out_idx;
    logic [15:0] frame_cnt;

    int n_cmp = 0, n_bad = 0, cyc = 0, n_acc = 0, c0 = 0, base = 0, a0 = 0;
    logic [15:0] exp_fc = '0;
    logic [W-1:0] fr [N], fi [N], er [N], ei [N];

    typedef struct packed {logic [1:0] idx; logic [W-1:0] re; logic [W-1:0] im; logic last;} obs_t;
    obs_t out_q [$];

    fft_stream_ctrl #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .in_ready(in_ready), .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .out_ready(out_ready), .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) n_acc <= n_acc + 1;
        if (out_valid && out_ready) out_q.push_back('{out_idx, out_re, out_im, out_last});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // X[k] = sum x[n] * (-j)^(nk), wrapped to W bits
    function automatic void model();
        for (int k = 0; k < N; k++) begin
            int sr = 0, si = 0;
            for (int n = 0; n < N; n++) begin
                int a = $signed(fr[n]);
                int b = $signed(fi[n]);
                case ((n * k) % 4)
                    0: begin sr += a; si += b; end
                    1: begin sr += b; si -= a; end
                    2: begin sr -= a; si -= b; end
                    default: begin sr -= b; si += a; end
                endcase
            end
            er[k] = W'(sr);
            ei[k] = W'(si);
        end
    endfunction

    task automatic rand_frame();
        for (int i = 0; i < N; i++) begin
            fr[i] = W'($urandom);
            fi[i] = W'($urandom);
        end
        model();
    endtask

    task automatic drive_frame(input bit gaps);
        int i = 0, g = 0;
        bit v = 0;
        while (i < N && g < 64) begin
            @(negedge clk);
            g++;
            v = gaps ? !v : 1'b1;
            in_valid = v;
            in_re = fr[i];
            in_im = fi[i];
            if (v && in_ready) begin
                if (i == 0) c0 = cyc;
                i++;
            end
            @(posedge clk);
        end
        chk("load_accepts", i, N);
    endtask

    task automatic wait_frame(input int cnt, input bit hb, input bit rnd);
        int g = 0;
        while (out_q.size() - base < cnt && g < 200) begin
            @(negedge clk);
            g++;
            in_valid = hb ? busy : 1'b0;
            if (rnd) out_ready = 1'($urandom);
        end
        chk("frame_done", out_q.size() - base >= cnt, 1);
    endtask

    task automatic check_bins(input string tag);
        chk({tag, "_nbins"}, out_q.size() - base, N);
        for (int i = 0; i < N; i++) begin
            obs_t e = (base + i < out_q.size()) ? out_q[base + i] : '0;
            chk({tag, "_idx"}, e.idx, i);
            chk({tag, "_re"}, e.re, er[i]);
            chk({tag, "_im"}, e.im, ei[i]);
            chk({tag, "_last"}, e.last, i == N - 1);
        end
        base += N;
        exp_fc++;
        @(negedge clk);
        chk({tag, "_fcnt"}, frame_cnt, exp_fc);
    endtask

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_re", out_re, 0);
        chk("rst_out_im", out_im, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fcnt", frame_cnt, 0);
        rst_n = 1;
        #1 chk("rel_ready_pre", in_ready, 0);
        @(negedge clk);
        chk("rel_ready_edge", in_ready, 1);

        // back-to-back impulse
        fr = '{12'd1, 12'd0, 12'd0, 12'd0};
        fi = '{default: '0};
        model();
        out_ready = 1;
        drive_frame(0);
        @(negedge clk);
        in_valid = busy;
        chk("lat_compute_valid", out_valid, 0);
        chk("lat_compute_ready", in_ready, 0);
        chk("lat_compute_busy", busy, 1);
        @(negedge clk);
        chk("lat_unload_valid", out_valid, 1);
        chk("lat_unload_idx", out_idx, 0);
        wait_frame(N, 1, 0);
        chk("period", cyc - c0, 2 * N + 1);
        chk("period_ready", in_ready, 1);
        check_bins("impulse");

        // backpressure on bin 2, DC frame
        fr = '{default: 12'd1};
        fi = '{default: '0};
        model();
        drive_frame(0);
        begin
            int g = 0;
            while (!(out_valid && out_idx == 2) && g < 20) begin
                @(negedge clk);
                in_valid = 0;
                g++;
            end
        end
        chk("bp_reach", out_valid && out_idx == 2, 1);
        out_ready = 0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_idx", out_idx, 2);
            chk("bp_re", out_re, er[2]);
            chk("bp_im", out_im, ei[2]);
        end
        out_ready = 1;
        wait_frame(N, 0, 0);
        check_bins("dc_bp");

        // input gaps, in_valid kept high while busy
        rand_frame();
        a0 = n_acc;
        drive_frame(1);
        wait_frame(N, 1, 0);
        chk("gap_accepts", n_acc - a0, N);
        check_bins("gaps");

        // random frames with random backpressure
        for (int f = 0; f < 5; f++) begin
            rand_frame();
            drive_frame(1'($urandom));
            wait_frame(N, 0, 1);
            check_bins("rand");
        end
        out_ready = 1;

        // reset after bin 1 of UNLOAD
        rand_frame();
        drive_frame(0);
        wait_frame(2, 0, 0);
        rst_n = 0;
        #1;
        chk("mrst_valid", out_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_idx", out_idx, 0);
        chk("mrst_re", out_re, 0);
        chk("mrst_ready", in_ready, 0);
        chk("mrst_fcnt", frame_cnt, 0);
        base = out_q.size();
        exp_fc = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("mrst_rel_ready", in_ready, 1);
        rand_frame();
        drive_frame(0);
        wait_frame(N, 0, 0);
        check_bins("post_rst");

        // frame_cnt wrap via preload
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt;
        @(negedge clk);
        chk("wrap_preload", frame_cnt, 16'hFFFF);
        exp_fc = 16'hFFFF;
        rand_frame();
        drive_frame(0);
        wait_frame(N, 0, 0);
        check_bins("wrap");
        chk("wrap_zero", frame_cnt, 0);
        rand_frame();
        drive_frame(0);
        wait_frame(N, 0, 1);
        check_bins("after_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
